sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO and successor to the fixed 32×32 `FIFO`. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. First-word-fall-through read timing is a compile-time option. It sits between producer/consumer stages in the general datapath library and is a drop-in for `FIFO` when default parameters are used and the new outputs are left unconnected.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_mem.sv | 57 +++++
 rtl/sync_fifo_param.sv | 173 +++++++++++++++++
 tb/tb_sync_fifo_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: width-derivation helpers shared by the FIFO variants.
// Pointers carry one extra wrap bit above the storage address; the
// occupancy count needs the same width so it can represent DEPTH itself.
package fifo_pkg;

    // Ceiling log2, valid for v >= 1 (returns 0 for v == 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Storage address width for a power-of-two depth.
    function automatic int addr_width(input int depth);
        return clog2(depth);
    endfunction

    // Pointer width: address bits plus the wrap bit.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Count width: enough to hold 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array, one write port and one read port.
// Configuration macro FIFO_FWFT_EN: when defined the read port is an
// asynchronous (combinational) read of the addressed entry; otherwise the
// read port is a registered output, loaded on re and reset to zero.
// Storage itself is never reset.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
`ifndef FIFO_FWFT_EN
    input  logic             rst_n,
    input  logic             re,
`endif
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    // Fall-through read: the addressed entry is visible immediately.
    always_comb begin
        rdata = mem_r[raddr];
    end
`else
    logic [WIDTH-1:0] rdata_r;

    // Registered read port: load the addressed word on an accepted read, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Drive the port from the read register.
    always_comb begin
        rdata = rdata_r;
    end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Configuration macro FIFO_FWFT_EN: when defined, data_out shows the head
// entry combinationally (first-word fall-through); otherwise data_out is a
// register loaded on each accepted read.
// Reset (rst_n) is synchronous and active-low.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4,
    localparam int AW       = addr_width(DEPTH),
    localparam int PW       = ptr_width(DEPTH),
    localparam int CW       = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic             read,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic          empty_r;
    logic          afull_r;
    logic          aempty_r;
    logic          ovf_r;
    logic          unf_r;

    logic          rd_acc_s;
    logic          wr_acc_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          full_nxt_s;
    logic          empty_nxt_s;
    logic          afull_nxt_s;
    logic          aempty_nxt_s;
    logic          ovf_nxt_s;
    logic          unf_nxt_s;

    // Accept rules: a read needs data; a write needs space or a same-cycle accepted read.
    always_comb begin
        rd_acc_s = read && !empty_r;
        wr_acc_s = write && (!full_r || rd_acc_s);
    end

    // Next pointers: plain binary increment, the carry into the MSB toggles the wrap bit.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Next occupancy: +1 write-only, -1 read-only, unchanged on both or neither.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Next status flags: full/empty from next pointers, thresholds from next count.
    always_comb begin
        full_nxt_s   = (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]) &&
                       (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        afull_nxt_s  = (count_nxt_s >= CW'(AF_THRESH));
        aempty_nxt_s = (count_nxt_s <= CW'(AE_THRESH));
    end

    // Sticky error flags: clear first, a new rejection in the same cycle wins.
    always_comb begin
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        if (err_clr) begin
            ovf_nxt_s = 1'b0;
            unf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
            unf_nxt_s = unf_r;
        end
        if (write && !wr_acc_s) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = ovf_nxt_s;
        end
        if (read && !rd_acc_s) begin
            unf_nxt_s = 1'b1;
        end else begin
            unf_nxt_s = unf_nxt_s;
        end
    end

    // State register: pointers, count, status and error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            afull_r  <= afull_nxt_s;
            aempty_r <= aempty_nxt_s;
            ovf_r    <= ovf_nxt_s;
            unf_r    <= unf_nxt_s;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
`ifndef FIFO_FWFT_EN
        .rst_n (rst_n),
        .re    (rd_acc_s),
`endif
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (data_out)
    );

    // Output mapping of the registered status.
    always_comb begin
        fifo_full    = full_r;
        fifo_empty   = empty_r;
        almost_full  = afull_r;
        almost_empty = aempty_r;
        count        = count_r;
        overflow     = ovf_r;
        underflow    = unf_r;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed checks of sync_fifo_param
// against a queue-based reference model. Instance a uses default
// parameters; instance b uses DEPTH=8, AF_THRESH=6, AE_THRESH=2.
module tb_sync_fifo_param;

    logic        clk;
    logic        rst_n;

    logic        a_write, a_read, a_clr;
    logic [31:0] a_din, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [5:0]  a_count;

    logic        b_write, b_read, b_clr;
    logic [31:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0]  b_count;

    int total;
    int bad;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] da, db;
    logic        oa, ua, ob, ub;

    sync_fifo_param u_a (
        .clk(clk), .rst_n(rst_n), .write(a_write), .read(a_read), .err_clr(a_clr),
        .data_in(a_din), .data_out(a_dout), .fifo_full(a_full), .fifo_empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_param #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .write(b_write), .read(b_read), .err_clr(b_clr),
        .data_in(b_din), .data_out(b_dout), .fifo_full(b_full), .fifo_empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_write = 1'b0; a_read = 1'b0; a_clr = 1'b0; a_din = 32'h0;
        b_write = 1'b0; b_read = 1'b0; b_clr = 1'b0; b_din = 32'h0;
    endtask

    task automatic check_outputs(input bit s);
        int n;
        if (!s) begin
            n = qa.size();
            check("a.count", 64'(a_count), 64'(n));
            check("a.full",  64'(a_full),  64'(n == 32));
            check("a.empty", 64'(a_empty), 64'(n == 0));
            check("a.af",    64'(a_af),    64'(n >= 28));
            check("a.ae",    64'(a_ae),    64'(n <= 4));
            check("a.ovf",   64'(a_ovf),   64'(oa));
            check("a.unf",   64'(a_unf),   64'(ua));
`ifdef FIFO_FWFT_EN
            if (n > 0) check("a.dout", 64'(a_dout), 64'(qa[0]));
`else
            check("a.dout", 64'(a_dout), 64'(da));
`endif
        end else begin
            n = qb.size();
            check("b.count", 64'(b_count), 64'(n));
            check("b.full",  64'(b_full),  64'(n == 8));
            check("b.empty", 64'(b_empty), 64'(n == 0));
            check("b.af",    64'(b_af),    64'(n >= 6));
            check("b.ae",    64'(b_ae),    64'(n <= 2));
            check("b.ovf",   64'(b_ovf),   64'(ob));
            check("b.unf",   64'(b_unf),   64'(ub));
`ifdef FIFO_FWFT_EN
            if (n > 0) check("b.dout", 64'(b_dout), 64'(qb[0]));
`else
            check("b.dout", 64'(b_dout), 64'(db));
`endif
        end
    endtask

    // One clock cycle of traffic on instance s (0 = a, 1 = b), the other idles.
    task automatic step(input bit s, input bit w, input bit r, input logic [31:0] d, input bit c);
        int  n;
        bit  rok;
        bit  wok;
        idle_inputs();
        if (!s) begin
            a_write = w; a_read = r; a_din = d; a_clr = c;
        end else begin
            b_write = w; b_read = r; b_din = d; b_clr = c;
        end
        @(posedge clk);
        if (!s) begin
            n   = qa.size();
            rok = r && (n > 0);
            wok = w && ((n < 32) || rok);
            if (rok) da = qa.pop_front();
            if (wok) qa.push_back(d);
            if (c) begin oa = 1'b0; ua = 1'b0; end
            if (w && !wok) oa = 1'b1;
            if (r && !rok) ua = 1'b1;
        end else begin
            n   = qb.size();
            rok = r && (n > 0);
            wok = w && ((n < 8) || rok);
            if (rok) db = qb.pop_front();
            if (wok) qb.push_back(d);
            if (c) begin ob = 1'b0; ub = 1'b0; end
            if (w && !wok) ob = 1'b1;
            if (r && !rok) ub = 1'b1;
        end
        #1;
        check_outputs(s);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        qa.delete(); qb.delete();
        da = 32'h0; db = 32'h0;
        oa = 1'b0; ua = 1'b0; ob = 1'b0; ub = 1'b0;
        #1;
        check_outputs(1'b0);
        check_outputs(1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int writes;
        bit w;
        bit r;
        bit c;
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;
        da = 32'h0; db = 32'h0;
        oa = 1'b0; ua = 1'b0; ob = 1'b0; ub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill to full with 0x0..0x1F; almost_full rises with the 28th word.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i), 1'b0);
            if (i == 26) check("af_before_28", 64'(a_af), 64'h0);
            if (i == 27) check("af_at_28", 64'(a_af), 64'h1);
        end
        // Rejected write sets a sticky overflow.
        step(1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

        // Full with simultaneous read and write.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 32'(i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hAA, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
`ifndef FIFO_FWFT_EN
        check("full_rw_last_word", 64'(a_dout), 64'hAA);
`endif

        // Empty with simultaneous read and write, then error clear.
        step(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
        check("empty_rw_unf", 64'(a_unf), 64'h1);
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Clear and a new error in the same cycle: set wins.
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);

        // Wrap-heavy random traffic on the 8-deep instance.
        writes = 0;
        for (int i = 0; i < 600 && writes < 40; i++) begin
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 19) == 0);
            if (w && ((qb.size() < 8) || (r && qb.size() > 0))) writes++;
            step(1'b1, w, r, $urandom, c);
        end
        check("b_40_writes", 64'(writes), 64'd40);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);

        // Random traffic on the default instance, phases biased to hit full and empty.
        for (int i = 0; i < 400; i++) begin
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 30);
            end else begin
                w = ($urandom_range(0, 99) < 30);
                r = ($urandom_range(0, 99) < 75);
            end
            c = ($urandom_range(0, 29) == 0);
            step(1'b0, w, r, $urandom, c);
        end

        // Reset mid-operation with 10 words held.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h1234, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
`ifndef FIFO_FWFT_EN
        check("post_reset_word", 64'(a_dout), 64'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
